// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU control encodings and
// the arbiter FSM state type.
package alu_pkg;

    localparam logic ALU_ADD  = 1'b1;
    localparam logic ALU_ZERO = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: finds the first set request at or after
// ptr (wrapping), and drives the one-hot grant only when enabled.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx
);

    logic found;
    int   idx;

    // grant_idx is computed regardless of en so the operand muxes settle early
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        if (en && found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// registered ALU inputs, one tagged response at a time over valid/ready.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int DATA_SIZE = 32,
    parameter  int CTRL_SIZE = 1,
    parameter  int NUM_REQ   = 2,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_op1,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_op2,
    input  logic [NUM_REQ*CTRL_SIZE-1:0] req_ctrl,
    output logic [DATA_SIZE-1:0]         ALUop1,
    output logic [DATA_SIZE-1:0]         ALUop2,
    output logic [CTRL_SIZE-1:0]         ALUctrl,
    input  logic [DATA_SIZE-1:0]         ALUout,
    input  logic                         EQ,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [DATA_SIZE-1:0]         rsp_data,
    output logic                         rsp_eq
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_t            state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       rsp_id_next;
    logic                  grant_en;
    logic                  accept;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       ptr_next;
    logic [DATA_SIZE-1:0]  sel_op1;
    logic [DATA_SIZE-1:0]  sel_op2;
    logic [CTRL_SIZE-1:0]  sel_ctrl;

    // Reset masks the grant so no requester sees an accept while reset is held
    assign grant_en = !rst && ((state == IDLE) || (state == RESP && rsp_ready));
    assign accept   = |grant_onehot;
    assign req_ready = grant_onehot;

    assign sel_op1  = req_op1[int'(grant_idx)*DATA_SIZE +: DATA_SIZE];
    assign sel_op2  = req_op2[int'(grant_idx)*DATA_SIZE +: DATA_SIZE];
    assign sel_ctrl = req_ctrl[int'(grant_idx)*CTRL_SIZE +: CTRL_SIZE];
    assign ptr_next = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .en          (grant_en),
        .grant_onehot(grant_onehot),
        .grant_idx   (grant_idx)
    );

    // An accept can only occur in IDLE or in RESP with the handshake, so the
    // operand load is shared by both paths ahead of the state case.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            rsp_id_next <= '0;
            ALUop1      <= '0;
            ALUop2      <= '0;
            ALUctrl     <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_eq      <= 1'b0;
        end else begin
            if (accept) begin
                ALUop1      <= sel_op1;
                ALUop2      <= sel_op2;
                ALUctrl     <= sel_ctrl;
                rsp_id_next <= grant_idx;
                rr_ptr      <= ptr_next;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= ALUout;
                    rsp_eq    <= EQ;
                    rsp_id    <= rsp_id_next;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [1:0]  req_ctrl;
    logic [31:0] aluOp1;
    logic [31:0] aluOp2;
    logic [0:0]  aluCtrl;
    logic [31:0] aluOut;
    logic        aluEq;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_eq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Bench-side ALU: add when ctrl is ALU_ADD, zero otherwise; EQ compares operands
    assign aluOut = (aluCtrl == ALU_ADD) ? aluOp1 + aluOp2 : 32'd0;
    assign aluEq  = (aluOp1 == aluOp2);

    alu_arbiter #(
        .DATA_SIZE(32),
        .CTRL_SIZE(1),
        .NUM_REQ  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op1  (req_op1),
        .req_op2  (req_op2),
        .req_ctrl (req_ctrl),
        .ALUop1   (aluOp1),
        .ALUop2   (aluOp2),
        .ALUctrl  (aluCtrl),
        .ALUout   (aluOut),
        .EQ       (aluEq),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .rsp_eq   (rsp_eq)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [1:0] v, input logic rr);
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        #1;
    endtask

    task automatic setOp(input int idx, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_op1[idx*32 +: 32] = a;
        req_op2[idx*32 +: 32] = b;
        req_ctrl[idx]         = c;
    endtask

    // Transaction model: an accepted op is in flight for one cycle, then
    // becomes the outstanding response until the consumer takes it.
    bit          checkEn = 0;
    int          cyc = 0;
    int          mPtr = 0;
    bit          mInflight = 0;
    bit          mOut = 0;
    int          mInId, mOutId;
    logic [31:0] mInData, mOutData;
    bit          mInEq, mOutEq;
    logic [31:0] mOp1 = 0, mOp2 = 0;
    logic        mCtrl = 0;
    bit          canAcc;
    int          mG, mJ;
    logic [1:0]  expReady;
    logic [31:0] mA, mB;
    int          grantLog[$];
    int          grantCyc[$];

    always @(negedge clk) begin
        if (checkEn) begin
            cyc++;
            canAcc = !rst && ((!mInflight && !mOut) || (mOut && rsp_ready));
            mG = -1;
            if (canAcc) begin
                for (int k = 0; k < 2; k++) begin
                    mJ = (mPtr + k) % 2;
                    if (mG < 0 && req_valid[mJ]) mG = mJ;
                end
            end
            expReady = (mG >= 0) ? (2'b01 << mG) : 2'b00;
            checkOutput("req_ready", 64'(req_ready), 64'(expReady));
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(mOut));
            checkOutput("ALUop1", 64'(aluOp1), 64'(mOp1));
            checkOutput("ALUop2", 64'(aluOp2), 64'(mOp2));
            checkOutput("ALUctrl", 64'(aluCtrl), 64'(mCtrl));
            if (mOut) begin
                checkOutput("rsp_data", 64'(rsp_data), 64'(mOutData));
                checkOutput("rsp_eq", 64'(rsp_eq), 64'(mOutEq));
                checkOutput("rsp_id", 64'(rsp_id), 64'(mOutId));
            end
            if (req_ready != 2'b00) begin
                grantLog.push_back(req_ready[1] ? 1 : 0);
                grantCyc.push_back(cyc);
            end
            if (rst) begin
                mPtr = 0; mInflight = 0; mOut = 0;
                mOp1 = 0; mOp2 = 0; mCtrl = 0;
            end else begin
                if (mOut && rsp_ready) mOut = 0;
                if (mInflight) begin
                    mOut = 1; mOutId = mInId; mOutData = mInData; mOutEq = mInEq;
                    mInflight = 0;
                end
                if (mG >= 0) begin
                    mA = req_op1[mG*32 +: 32];
                    mB = req_op2[mG*32 +: 32];
                    mInflight = 1;
                    mInId     = mG;
                    mInData   = req_ctrl[mG] ? mA + mB : 32'd0;
                    mInEq     = (mA == mB);
                    mOp1 = mA; mOp2 = mB; mCtrl = req_ctrl[mG];
                    mPtr = (mG + 1) % 2;
                end
            end
        end
    end

    task automatic runOp(input int idx, input logic [31:0] a, input logic [31:0] b, input logic c,
                         output logic [31:0] d, output logic e, output logic [0:0] id);
        int n;
        setOp(idx, a, b, c);
        applyStimulus(1'b0, 2'(1 << idx), 1'b0);
        n = 0;
        while (req_ready[idx] == 1'b0 && n < 8) begin
            tick();
            n++;
        end
        if (n == 8) checkOutput("accept timeout", 64'(0), 64'(1));
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0);
        n = 0;
        while (!rsp_valid && n < 8) begin
            tick();
            n++;
        end
        if (n == 8) checkOutput("response timeout", 64'(0), 64'(1));
        d  = rsp_data;
        e  = rsp_eq;
        id = rsp_id;
        applyStimulus(1'b0, 2'b00, 1'b1);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [0:0]  id;

        req_op1 = '0; req_op2 = '0; req_ctrl = '0;
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;

        // Reset held two cycles with both requesters asking
        tick();
        checkEn = 1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset req_ready", 64'(req_ready), 64'(0));
            checkOutput("reset rsp_valid", 64'(rsp_valid), 64'(0));
            checkOutput("reset ALUop1", 64'(aluOp1), 64'(0));
            checkOutput("reset ALUop2", 64'(aluOp2), 64'(0));
            checkOutput("reset ALUctrl", 64'(aluCtrl), 64'(0));
            if (i == 0) tick();
        end

        // Single op: 5 + 7 from requester 0
        setOp(0, 32'd5, 32'd7, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0);
        checkOutput("single req_ready", 64'(req_ready), 64'(2'b01));
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("single ALUop1", 64'(aluOp1), 64'(5));
        checkOutput("single ALUop2", 64'(aluOp2), 64'(7));
        checkOutput("single early rsp_valid", 64'(rsp_valid), 64'(0));
        tick();
        checkOutput("single rsp_valid", 64'(rsp_valid), 64'(1));
        checkOutput("single rsp_data", 64'(rsp_data), 64'(12));
        checkOutput("single rsp_eq", 64'(rsp_eq), 64'(0));
        checkOutput("single rsp_id", 64'(rsp_id), 64'(0));
        applyStimulus(1'b0, 2'b00, 1'b1);
        tick();
        checkOutput("single drained", 64'(rsp_valid), 64'(0));

        // Contention from a fresh pointer
        applyStimulus(1'b1, 2'b00, 1'b1);
        tick();
        setOp(0, 32'd10, 32'd20, 1'b1);
        setOp(1, 32'd100, 32'd3, 1'b1);
        grantLog.delete();
        grantCyc.delete();
        applyStimulus(1'b0, 2'b11, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        applyStimulus(1'b0, 2'b00, 1'b1);
        tick();
        checkOutput("contention grants", 64'(grantLog.size()), 64'(4));
        for (int i = 0; i < grantLog.size() && i < 4; i++)
            checkOutput("contention id", 64'(grantLog[i]), 64'(i % 2));
        for (int i = 1; i < grantCyc.size() && i < 4; i++)
            checkOutput("contention spacing", 64'(grantCyc[i] - grantCyc[i-1]), 64'(2));

        // Backpressure: response held five cycles, then release grants requester 1
        setOp(0, 32'd1, 32'd2, 1'b1);
        setOp(1, 32'd3, 32'd4, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b0);
        checkOutput("bp first grant", 64'(req_ready), 64'(2'b01));
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp req_ready", 64'(req_ready), 64'(0));
            checkOutput("bp rsp_valid", 64'(rsp_valid), 64'(1));
            checkOutput("bp rsp_data", 64'(rsp_data), 64'(3));
            checkOutput("bp rsp_id", 64'(rsp_id), 64'(0));
            tick();
        end
        applyStimulus(1'b0, 2'b11, 1'b1);
        checkOutput("bp release grant", 64'(req_ready), 64'(2'b10));
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0);
        tick();
        checkOutput("bp second rsp_data", 64'(rsp_data), 64'(7));
        checkOutput("bp second rsp_id", 64'(rsp_id), 64'(1));
        applyStimulus(1'b0, 2'b00, 1'b1);
        tick();

        // Wrap-around add and equality flag with zero control
        runOp(0, 32'hFFFF_FFFF, 32'd1, 1'b1, d, e, id);
        checkOutput("wrap data", 64'(d), 64'(0));
        checkOutput("wrap eq", 64'(e), 64'(0));
        checkOutput("wrap id", 64'(id), 64'(0));
        runOp(1, 32'd9, 32'd9, 1'b0, d, e, id);
        checkOutput("eq data", 64'(d), 64'(0));
        checkOutput("eq flag", 64'(e), 64'(1));
        checkOutput("eq id", 64'(id), 64'(1));

        // Reset pulsed while an op executes: no response, pointer back to 0
        setOp(0, 32'd2, 32'd2, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b00, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("midreset rsp_valid", 64'(rsp_valid), 64'(0));
        tick();
        checkOutput("midreset no late rsp", 64'(rsp_valid), 64'(0));
        setOp(1, 32'd5, 32'd6, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b1);
        checkOutput("midreset ptr zero", 64'(req_ready), 64'(2'b01));
        tick();
        applyStimulus(1'b0, 2'b00, 1'b1);
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
